// File: rtl/nes_joypad_pkg.sv
// Shared constants and helpers for the NES controller emulator.
package nes_joypad_pkg;

  localparam int unsigned BUTTON_COUNT  = 8;
  localparam int unsigned BIT_COUNT_MAX = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef logic [BUTTON_COUNT-1:0] buttons_t;

  function automatic logic [3:0] bit_count_inc(input logic [3:0] count);
    if (count >= 4'(BIT_COUNT_MAX)) begin
      return 4'(BIT_COUNT_MAX);
    end
    return count + 4'd1;
  endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Single-button debouncer: a new level is accepted only after it has been
// seen for DEBOUNCE_CYCLES consecutive clocks.
module joypad_debounce
  import nes_joypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = raw;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/nes_joypad.sv
// NES controller emulator: synchronizes console strobes, debounces buttons and
// serializes the latched button byte LSB-first, shifting 1s in behind it.
module nes_joypad
  import nes_joypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [BUTTON_COUNT-1:0] i_buttons,
  input  logic                    i_latch,
  input  logic                    i_shift_clk,
  output logic                    o_data,
  output logic [BUTTON_COUNT-1:0] o_debug_buttons,
  output logic [3:0]              o_debug_bit_count
);

  logic [SYNC_STAGES-1:0]                   latch_sync_q;
  logic [SYNC_STAGES-1:0]                   sclk_sync_q;
  logic [SYNC_STAGES-1:0][BUTTON_COUNT-1:0] btn_sync_q;
  logic                                     sclk_prev_q;

  logic     latch_s, sclk_s, shift_edge;
  buttons_t btn_s;
  buttons_t sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;

  // Shift clock idles high, so its synchronizer resets high to avoid a false edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      latch_sync_q <= '0;
      sclk_sync_q  <= '1;
      btn_sync_q   <= '0;
      sclk_prev_q  <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], i_latch};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], i_shift_clk};
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], i_buttons};
      sclk_prev_q  <= sclk_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign btn_s      = btn_sync_q[SYNC_STAGES-1];
  assign shift_edge = sclk_s & ~sclk_prev_q;

  for (genvar b = 0; b < BUTTON_COUNT; b++) begin : g_debounce
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (i_clk),
      .reset (i_reset),
      .raw   (btn_s[b]),
      .stable(o_debug_buttons[b])
    );
  end

  // Latch level dominates shifting; the register is reloaded every latched cycle.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (latch_s) begin
      sr_d  = o_debug_buttons;
      cnt_d = 4'd0;
    end else if (shift_edge) begin
      sr_d  = {1'b1, sr_q[BUTTON_COUNT-1:1]};
      cnt_d = bit_count_inc(cnt_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sr_q  <= '0;
      cnt_q <= 4'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_data            = sr_q[0];
  assign o_debug_bit_count = cnt_q;

endmodule

// File: tb/tb_nes_joypad.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_nes_joypad;

  localparam int unsigned DEB = 16;
  localparam int unsigned S   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       latch = 1'b0;
  logic       sclk = 1'b1;
  logic       data;
  logic [7:0] dbg;
  logic [3:0] bcnt;

  int errors = 0;
  int checks = 0;

  nes_joypad #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (S)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_buttons        (buttons),
    .i_latch          (latch),
    .i_shift_clk      (sclk),
    .o_data           (data),
    .o_debug_buttons  (dbg),
    .o_debug_bit_count(bcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs are seen S clocks late; the serial stream is the
  // loaded byte indexed by the number of shifts since the load, then all 1s.
  logic [7:0] m_bdel [S];
  logic       m_ldel [S];
  logic       m_sdel [S];
  logic       m_sprev;
  logic [7:0] m_stable;
  int         m_run [8];
  logic [7:0] m_loaded;
  int         m_n;
  bit         model_ok = 0;
  logic [7:0] b_s;
  logic       l_s, s_s;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        m_bdel[i] = 8'h00;
        m_ldel[i] = 1'b0;
        m_sdel[i] = 1'b1;
      end
      m_sprev  = 1'b1;
      m_stable = 8'h00;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
      m_loaded = 8'h00;
      m_n      = 0;
      model_ok = 1;
    end else begin
      b_s = m_bdel[S-1];
      l_s = m_ldel[S-1];
      s_s = m_sdel[S-1];
      if (l_s) begin
        m_loaded = m_stable;
        m_n      = 0;
      end else if (s_s && !m_sprev) begin
        m_n = (m_n >= 8) ? 8 : m_n + 1;
      end
      m_sprev = s_s;
      for (int b = 0; b < 8; b++) begin
        if (b_s[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_stable[b] = b_s[b];
            m_run[b]    = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      for (int i = S - 1; i > 0; i--) begin
        m_bdel[i] = m_bdel[i-1];
        m_ldel[i] = m_ldel[i-1];
        m_sdel[i] = m_sdel[i-1];
      end
      m_bdel[0] = buttons;
      m_ldel[0] = latch;
      m_sdel[0] = sclk;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_data", {7'd0, data}, (m_n < 8) ? {7'd0, m_loaded[m_n]} : 8'h01);
      check("model_buttons", dbg, m_stable);
      check("model_count", {4'd0, bcnt}, 8'(m_n));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pulse(input int lo = 4, input int hi = 4);
    sclk = 1'b0;
    cyc(lo);
    sclk = 1'b1;
    cyc(hi);
  endtask

  task automatic latch_pulse(input int hi = 4, input int lo = 4);
    latch = 1'b1;
    cyc(hi);
    latch = 1'b0;
    cyc(lo);
  endtask

  task automatic settle_buttons(input logic [7:0] v);
    buttons = v;
    cyc(DEB + S + 2);
  endtask

  logic [7:0] seq09;

  initial begin
    cyc(3);
    rst = 1'b0;
    check("reset_data", {7'd0, data}, 8'h00);
    check("reset_buttons", dbg, 8'h00);
    check("reset_count", {4'd0, bcnt}, 8'h00);

    // 8'h09 read out LSB first, then trailing 1s with a saturated count.
    seq09 = 8'h09;
    settle_buttons(8'h09);
    check("deb_09", dbg, 8'h09);
    latch_pulse();
    for (int k = 0; k < 8; k++) begin
      check("seq09_bit", {7'd0, data}, {7'd0, seq09[k]});
      shift_pulse();
    end
    for (int k = 0; k < 5; k++) begin
      check("trail_one", {7'd0, data}, 8'h01);
      check("trail_count", {4'd0, bcnt}, 8'h08);
      if (k < 4) shift_pulse();
    end

    // Short glitch on A is rejected.
    settle_buttons(8'h00);
    buttons = 8'h01;
    cyc(DEB - 2);
    buttons = 8'h00;
    cyc(DEB + S + 2);
    check("glitch_rejected", dbg, 8'h00);

    // Shifts while latched keep presenting A.
    settle_buttons(8'h01);
    latch = 1'b1;
    cyc(4);
    for (int k = 0; k < 3; k++) begin
      shift_pulse();
      check("latched_data", {7'd0, data}, 8'h01);
      check("latched_count", {4'd0, bcnt}, 8'h00);
    end
    latch = 1'b0;
    cyc(4);
    check("after_latch_a", {7'd0, data}, 8'h01);
    shift_pulse();
    check("after_latch_b", {7'd0, data}, 8'h00);

    // Reset mid-read clears everything; subsequent shifts bring in 1s.
    settle_buttons(8'hFF);
    latch_pulse();
    for (int k = 0; k < 3; k++) shift_pulse();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midreset_data", {7'd0, data}, 8'h00);
    check("midreset_count", {4'd0, bcnt}, 8'h00);
    shift_pulse();
    check("post_reset_shift", {7'd0, data}, 8'h00);
    for (int k = 1; k < 8; k++) shift_pulse();
    check("post_reset_ones", {7'd0, data}, 8'h01);

    // Button changes after the load do not disturb the read.
    settle_buttons(8'h01);
    latch_pulse();
    settle_buttons(8'h80);
    check("deb_80", dbg, 8'h80);
    check("held_a", {7'd0, data}, 8'h01);
    for (int k = 1; k < 8; k++) begin
      shift_pulse();
      check("held_rest", {7'd0, data}, 8'h00);
    end

    // Randomized traffic checked by the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          buttons = 8'($urandom);
          cyc($urandom_range(1, 2 * DEB));
        end
        1: latch_pulse($urandom_range(1, 6), $urandom_range(1, 6));
        2, 3: shift_pulse($urandom_range(1, 6), $urandom_range(1, 6));
        4: begin
          if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1;
            cyc($urandom_range(1, 2));
            rst = 1'b0;
          end
          cyc($urandom_range(1, 4));
        end
        default: begin
          latch = 1'b1;
          cyc($urandom_range(1, 4));
          shift_pulse($urandom_range(1, 5), $urandom_range(1, 5));
          latch = 1'b0;
          cyc($urandom_range(1, 5));
        end
      endcase
    end

    cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
